jtkunio_colmix: RTL and testbench
=================================

Name: jtkunio_colmix

Overview:
- Final video stage of the Kunio core, directly downstream of the scroll tile layer and the object layer.
- Each pixel it takes the 6-bit scroll pixel and the 6-bit object pixel and resolves priority.
- It looks up a CPU-writable 128-entry, 12-bit palette and drives 4-bit RGB with aligned blanking.
- It also gives the CPU byte read/write access to the palette RAM.

Parameters:
- BLANK_DLY, 2, pxl_cen delay applied to blanking; must equal the pixel pipeline latency.
- SIMFILE_LO, "pal_lo.bin", simulation preload for the RG byte bank.
- SIMFILE_HI, "pal_hi.bin", simulation preload for the B byte bank.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pxl_cen  in  1  pixel clock enable; never high on two consecutive clk cycles
- preLHBL  in  1  horizontal blank, active low, aligned with the input pixels
- preLVBL  in  1  vertical blank, active low, aligned with the input pixels
- scr_pxl  in  6  scroll pixel {pal[2:0], col[2:0]}
- obj_pxl  in  6  object pixel {pal[2:0], col[2:0]}; col==0 means transparent
- cpu_addr  in  8  [6:0] palette entry, [7] byte select (0=RG, 1=B)
- pal_cs  in  1  palette chip select
- cpu_wrn  in  1  write strobe, active low
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data
- red  out  4  red output
- green  out  4  green output
- blue  out  4  blue output
- LHBL  out  1  delayed horizontal blank
- LVBL  out  1  delayed vertical blank
- gfx_en  in  2  debug layer enables: [0]=scroll, [1]=objects

Behaviour:
- Reset: asynchronous and active-high. While rst is high, red, green, blue, LHBL, LVBL and all pipeline registers are 0. Palette RAM contents are not cleared. cpu_din is undefined until the first read cycle.

Stage 1, on pxl_cen:
- obj_vis = gfx_en[1] & (obj_pxl[2:0]!=0).
- idx <= obj_vis ? {1'b1, obj_pxl} : {1'b0, scr_pxl}.
- If gfx_en[0]=0 and obj_vis=0, idx is forced to 7'h00 and black_n is cleared. black_n is set otherwise.

Stage 2, palette read:
- The scan port of the dual-port RAM is addressed by idx and gives synchronous read data one clk later.
- Word layout: lo byte {R[3:0], G[3:0]}, hi byte {4'd0, B[3:0]}.

Stage 3, on the next pxl_cen:
- If the delayed LHBL & LVBL & black_n is 1: {red, green, blue} <= RAM data.
- Otherwise they are <= 0.

Latency and blanking:
- Input pixel to RGB latency is exactly 2 pxl_cen edges.
- preLHBL/preLVBL pass through a BLANK_DLY-deep shift register clocked by pxl_cen, so LHBL/LVBL stay aligned with RGB.

CPU port:
- Write: when pal_cs & ~cpu_wrn, byte bank cpu_addr[7] at entry cpu_addr[6:0] is written with cpu_dout on every clk edge. Writes are independent of pxl_cen.
- Read: cpu_din = selected byte of the CPU-port RAM output, registered, 1 clk latency. The upper nibble of the B byte reads back as written.

Collisions and wrap-around:
- A CPU write and a scan read of the same entry in the same clk: the scan port returns the old value. The new colour appears from the next pixel that reads that entry.
- idx covers 0..127 exactly; there is no wrap-around beyond 7 bits.
- A reset asserted mid-frame clears the pipeline immediately. The first valid RGB appears 2 pxl_cen after rst falls.

Test Plan:
- Palette CPU access: write entry 0x05 lo=0xA3 (cpu_addr=0x05), hi=0x0C (cpu_addr=0x85); read both back -> cpu_din=0xA3 then 0x0C, each 1 clk after the address.
- Priority: with entry 0x05 as above, scr_pxl=6'o05 and obj_pxl=6'o00 -> red=0xA, green=0x3, blue=0xC exactly 2 pxl_cen later. Then obj_pxl=6'o21 -> output shows entry 0x51.
- Blanking: drop preLHBL for 8 pixels with non-black pixels in -> LHBL low for exactly those 8 pixels delayed by 2 pxl_cen, and RGB=0 during them.
- Layer debug: gfx_en=2'b01, obj_pxl=6'o21 -> scroll entry shown. gfx_en=2'b00 -> RGB=0 with blanks inactive.
- Collision: CPU writes entry 0x05 lo=0xFF on the same clk the scan port reads 0x05 -> that pixel outputs the old 0xA3 value and the next pixel outputs R=F, G=F.
- Reset: assert rst for 3 clk mid-line -> red/green/blue/LHBL/LVBL go to 0 asynchronously. Palette contents survive, and entry 0x05 reads back 0xFF (the value written in the collision test).

Source files
------------

// File: rtl/jtkunio_colmix.sv
// jtkunio_colmix: scroll/object priority, 128x12 palette lookup and blank-aligned RGB output
module jtkunio_colmix #(
    parameter int BLANK_DLY  = 2,
    parameter     SIMFILE_LO = "pal_lo.bin",
    parameter     SIMFILE_HI = "pal_hi.bin"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       preLHBL,
    input  logic       preLVBL,
    input  logic [5:0] scr_pxl,
    input  logic [5:0] obj_pxl,
    input  logic [7:0] cpu_addr,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL,
    output logic       LVBL,
    input  logic [1:0] gfx_en
);
    logic [7:0]           r_pal_lo [0:127];
    logic [7:0]           r_pal_hi [0:127];
    logic [6:0]           r_idx;
    logic                 r_black_n;
    logic                 r_rd;
    logic [11:0]          r_scan;
    logic [11:0]          r_rgb;
    logic [7:0]           r_cpu_din;
    logic [BLANK_DLY-1:0] r_hb;
    logic [BLANK_DLY-1:0] r_vb;
    logic                 w_obj_vis;
    logic                 w_show;
    logic [6:0]           w_cpu_a;

    // Preload file names are only meaningful to simulation loaders outside this RTL
    if ($bits(SIMFILE_LO) == 0 || $bits(SIMFILE_HI) == 0) begin : g_nofile
    end

    assign w_obj_vis = gfx_en[1] & (obj_pxl[2:0] != 3'd0);
    assign w_show    = r_hb[0] & r_vb[0] & r_black_n;
    assign w_cpu_a   = cpu_addr[6:0];
    assign cpu_din   = r_cpu_din;
    assign {red, green, blue} = r_rgb;
    assign LHBL      = r_hb[BLANK_DLY-1];
    assign LVBL      = r_vb[BLANK_DLY-1];

    // Stage 1: priority resolve into a palette index, and blanking delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= 7'h00;
            r_black_n <= 1'b0;
            r_hb      <= '0;
            r_vb      <= '0;
        end else if (pxl_cen) begin
            r_idx     <= w_obj_vis ? {1'b1, obj_pxl} : gfx_en[0] ? {1'b0, scr_pxl} : 7'h00;
            r_black_n <= w_obj_vis | gfx_en[0];
            r_hb      <= {r_hb[BLANK_DLY-2:0], preLHBL};
            r_vb      <= {r_vb[BLANK_DLY-2:0], preLVBL};
        end
    end

    // CPU port: byte writes and registered byte read-back (old data on same-clk write)
    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_wrn) begin
            if (cpu_addr[7]) r_pal_hi[w_cpu_a] <= cpu_dout;
            else             r_pal_lo[w_cpu_a] <= cpu_dout;
        end
        r_cpu_din <= cpu_addr[7] ? r_pal_hi[w_cpu_a] : r_pal_lo[w_cpu_a];
    end

    // Stage 2: scan port read once, on the clk right after idx loads, so a colliding write yields old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd   <= 1'b0;
            r_scan <= 12'h000;
        end else begin
            r_rd <= pxl_cen;
            if (r_rd) r_scan <= {r_pal_lo[r_idx], r_pal_hi[r_idx][3:0]};
        end
    end

    // Stage 3: gated colour output, blanking checked for the same pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_rgb <= 12'h000;
        else if (pxl_cen) r_rgb <= w_show ? r_scan : 12'h000;
    end
endmodule

// File: tb/tb_jtkunio_colmix.sv
// tb_jtkunio_colmix: directed and random checks of jtkunio_colmix against a palette/queue model
module tb_jtkunio_colmix;
    logic       clk = 0, rst = 1, pxl_cen = 0, preLHBL = 0, preLVBL = 0;
    logic       pal_cs = 0, cpu_wrn = 1;
    logic [5:0] scr_pxl = 0, obj_pxl = 0;
    logic [7:0] cpu_addr = 0, cpu_dout = 0;
    logic [1:0] gfx_en = 2'b11;
    logic [7:0] cpu_din;
    logic [3:0] red, green, blue;
    logic       LHBL, LVBL;
    int         n_chk = 0, n_pass = 0;
    logic [7:0] m_lo [128];
    logic [7:0] m_hi [128];
    logic [13:0] q[$];

    jtkunio_colmix dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .preLHBL(preLHBL), .preLVBL(preLVBL),
        .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .cpu_addr(cpu_addr), .pal_cs(pal_cs),
        .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .red(red),
        .green(green), .blue(blue), .LHBL(LHBL), .LVBL(LVBL), .gfx_en(gfx_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    // Expected {rgb, LHBL, LVBL} for one input pixel, from the priority rules
    function automatic logic [13:0] model(input logic [5:0] s, input logic [5:0] o,
                                          input logic h, input logic v, input logic [1:0] g);
        logic ov, on;
        int   idx;
        ov  = g[1] && (o % 8 != 0);
        idx = ov ? 64 + int'(o) : int'(s);
        on  = h && v && (ov || g[0]);
        return {on ? {m_lo[idx], m_hi[idx][3:0]} : 12'h000, h, v};
    endfunction

    task automatic mwrite(input logic [7:0] a, input logic [7:0] d);
        if (a[7]) m_hi[a[6:0]] = d;
        else      m_lo[a[6:0]] = d;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        pal_cs = 1; cpu_wrn = 0; cpu_addr = a; cpu_dout = d;
        @(negedge clk);
        pal_cs = 0; cpu_wrn = 1;
        mwrite(a, d);
    endtask

    task automatic cpu_rd(input logic [7:0] a);
        pal_cs = 1; cpu_wrn = 1; cpu_addr = a;
        @(negedge clk);
        chk("cpu_rd", cpu_din, a[7] ? m_hi[a[6:0]] : m_lo[a[6:0]]);
        pal_cs = 0;
    endtask

    // One pixel: cen for one clk, optional CPU write on the scan-read clk, then one idle clk
    task automatic px(input logic [5:0] s, input logic [5:0] o, input logic h, input logic v,
                      input logic wr = 0, input logic [7:0] wa = 0, input logic [7:0] wd = 0);
        logic [13:0] e;
        scr_pxl = s; obj_pxl = o; preLHBL = h; preLVBL = v; pxl_cen = 1;
        q.push_back(model(s, o, h, v, gfx_en));
        @(negedge clk);
        pxl_cen = 0;
        e = q.pop_front();
        chk("rgb", {red, green, blue}, e[13:2]);
        chk("blank", {LHBL, LVBL}, e[1:0]);
        if (wr) begin pal_cs = 1; cpu_wrn = 0; cpu_addr = wa; cpu_dout = wd; end
        @(negedge clk);
        if (wr) begin pal_cs = 0; cpu_wrn = 1; mwrite(wa, wd); end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_blank", {LHBL, LVBL}, 2'b00);
        rst = 0;
        for (int i = 0; i < 256; i++) cpu_wr(8'(i), 8'($urandom));
        cpu_wr(8'h05, 8'hA3);
        cpu_wr(8'h85, 8'h0C);
        cpu_rd(8'h05);
        chk("rd_lo", cpu_din, 8'hA3);
        cpu_rd(8'h85);
        chk("rd_hi", cpu_din, 8'h0C);
        q.delete();
        q.push_back(14'h0);
        // priority
        px(6'o05, 6'o00, 1, 1);
        px(6'o05, 6'o21, 1, 1);
        chk("prio_scr", {red, green, blue}, 12'hA3C);
        px(6'o05, 6'o00, 1, 1);
        chk("prio_obj", {red, green, blue}, {m_lo[7'h51], m_hi[7'h51][3:0]});
        // horizontal blanking window of 8 pixels
        for (int i = 0; i < 12; i++) px(6'o05, 6'o21, !(i >= 2 && i < 10), 1);
        px(6'o05, 6'o00, 1, 0);
        px(6'o05, 6'o00, 1, 1);
        // debug layer enables
        gfx_en = 2'b01;
        px(6'o05, 6'o21, 1, 1);
        px(6'o05, 6'o21, 1, 1);
        chk("dbg_scr", {red, green, blue}, 12'hA3C);
        gfx_en = 2'b00;
        px(6'o05, 6'o21, 1, 1);
        px(6'o05, 6'o21, 1, 1);
        chk("dbg_off", {red, green, blue}, 12'h000);
        chk("dbg_blank", {LHBL, LVBL}, 2'b11);
        gfx_en = 2'b11;
        // write/scan collision on entry 0x05
        px(6'o05, 6'o00, 1, 1, 1, 8'h05, 8'hFF);
        px(6'o05, 6'o00, 1, 1);
        chk("coll_old", {red, green, blue}, 12'hA3C);
        px(6'o05, 6'o00, 1, 1);
        chk("coll_new", {red, green}, 8'hFF);
        // reset mid-line
        px(6'o05, 6'o00, 1, 1);
        rst = 1;
        #1;
        chk("mid_rst_rgb", {red, green, blue}, 12'h000);
        chk("mid_rst_blank", {LHBL, LVBL}, 2'b00);
        repeat (3) @(negedge clk);
        rst = 0;
        q.delete();
        q.push_back(14'h0);
        cpu_rd(8'h05);
        chk("rd_keep", cpu_din, 8'hFF);
        px(6'o05, 6'o00, 1, 1);
        px(6'o05, 6'o00, 1, 1);
        chk("post_rst", {red, green, blue}, 12'hFFC);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            gfx_en = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 7) == 0) cpu_wr(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 7) == 0) cpu_rd(8'($urandom));
            px(6'($urandom), 6'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 5) == 0, 8'($urandom), 8'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
